// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - 3x3 sliding window generator fed by two line buffers.
// Tracks raster position to flag only fully in-frame windows and end of frame.
module window_gen_3x3 #(
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  row0_in,
    input  logic [7:0]  row1_in,
    input  logic [7:0]  row2_in,
    output logic [71:0] win_out,
    output logic        win_valid,
    output logic        frame_done
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    localparam logic [CW-1:0] COL_LAST      = CW'(WIDTH - 1);
    localparam logic [CW-1:0] COL_MIN_VALID = CW'(2);
    localparam logic [RW-1:0] ROW_LAST      = RW'(HEIGHT - 1);
    localparam logic [RW-1:0] ROW_FILL_LAST = RW'(1);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_last;
    logic          row_last;

    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_out    <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            col        <= '0;
            row        <= '0;
            state      <= FILL;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (en) begin
                // Each 24-bit row slice shifts toward c=0; the new column enters at c=2.
                win_out <= {row0_in, win_out[71:56],
                            row1_in, win_out[47:32],
                            row2_in, win_out[23:8]};

                win_valid  <= (state == RUN) && (col >= COL_MIN_VALID);
                frame_done <= col_last && row_last;

                if (col_last) begin
                    col <= '0;
                    if (row_last) begin
                        row <= '0;
                    end else begin
                        row <= row + RW'(1);
                    end
                end else begin
                    col <= col + CW'(1);
                end

                case (state)
                    FILL: if (col_last && (row == ROW_FILL_LAST)) state <= RUN;
                    RUN:  if (col_last && row_last) state <= FILL;
                    default: state <= FILL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb/tb_window_gen_3x3.sv - self-checking bench for window_gen_3x3.
module tb_window_gen_3x3;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  row0_in;
    logic [7:0]  row1_in;
    logic [7:0]  row2_in;
    logic [71:0] win_out;
    logic        win_valid;
    logic        frame_done;

    always #5 clk = ~clk;

    window_gen_3x3 #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .row0_in    (row0_in),
        .row1_in    (row1_in),
        .row2_in    (row2_in),
        .win_out    (win_out),
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the last three accepted columns plus the raster index in the frame.
    logic [23:0] hist [3];
    int          pos;
    logic        m_valid;
    logic        m_done;

    int vcnt;
    int dcnt;
    int sent;
    int done_at [$];

    typedef struct {
        int          p;
        logic        exp_valid;
        logic        exp_done;
        logic        chk_win;
        logic [71:0] exp_win;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] model_win();
        logic [71:0] w;
        w = '0;
        for (int c = 0; c < 3; c++) begin
            w[8*c     +: 8] = hist[c][23:16];
            w[8*(3+c) +: 8] = hist[c][15:8];
            w[8*(6+c) +: 8] = hist[c][7:0];
        end
        return w;
    endfunction

    function automatic logic [71:0] mkwin(input int a, input int b, input int c,
                                          input int d, input int e, input int f,
                                          input int g, input int h, input int i);
        return {8'(i), 8'(h), 8'(g), 8'(f), 8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) hist[k] = '0;
        pos     = 0;
        m_valid = 1'b0;
        m_done  = 1'b0;
    endtask

    task automatic cycle(input logic e, input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2);
        en      = e;
        row0_in = a0;
        row1_in = a1;
        row2_in = a2;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_valid = 1'b0;
            m_done  = 1'b0;
            if (e) begin
                hist[0] = hist[1];
                hist[1] = hist[2];
                hist[2] = {a2, a1, a0};
                m_valid = ((pos / W) >= 2) && ((pos % W) >= 2);
                m_done  = (pos == W*H - 1);
                pos     = (pos + 1) % (W*H);
                sent++;
            end
        end
        chk("model_win", win_out, model_win());
        chk("model_valid", 72'(win_valid), 72'(m_valid));
        chk("model_done", 72'(frame_done), 72'(m_done));
        if (win_valid) vcnt++;
        if (frame_done) begin
            dcnt++;
            done_at.push_back(sent);
        end
    endtask

    task automatic send(input int p);
        cycle(1'b1, 8'(p), (p > 4) ? 8'(p - 4) : 8'd0, (p > 8) ? 8'(p - 8) : 8'd0);
    endtask

    task automatic clear_counts();
        vcnt = 0;
        dcnt = 0;
        sent = 0;
        done_at.delete();
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 16; i++) begin
            send(tbl[i].p);
            chk({tag, "_valid"}, 72'(win_valid), 72'(tbl[i].exp_valid));
            chk({tag, "_done"}, 72'(frame_done), 72'(tbl[i].exp_done));
            if (tbl[i].chk_win) chk({tag, "_win"}, win_out, tbl[i].exp_win);
        end
    endtask

    initial begin
        model_reset();
        clear_counts();
        en      = 1'b0;
        row0_in = '0;
        row1_in = '0;
        row2_in = '0;

        for (int i = 0; i < 16; i++) begin
            tbl[i].p         = i + 1;
            tbl[i].exp_valid = (i + 1 == 11) || (i + 1 == 12) || (i + 1 == 15) || (i + 1 == 16);
            tbl[i].exp_done  = (i + 1 == 16);
            tbl[i].chk_win   = tbl[i].exp_valid;
            tbl[i].exp_win   = '0;
        end
        tbl[10].exp_win = mkwin(1, 2, 3, 5, 6, 7, 9, 10, 11);
        tbl[11].exp_win = mkwin(2, 3, 4, 6, 7, 8, 10, 11, 12);
        tbl[14].exp_win = mkwin(5, 6, 7, 9, 10, 11, 13, 14, 15);
        tbl[15].exp_win = mkwin(6, 7, 8, 10, 11, 12, 14, 15, 16);

        // Reset held with en toggling and live data.
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'(i % 2), 8'($urandom), 8'($urandom), 8'($urandom));
            chk("rst_win", win_out, 72'd0);
            chk("rst_valid", 72'(win_valid), 72'd0);
            chk("rst_done", 72'(frame_done), 72'd0);
        end
        rst_n = 1'b1;

        // Single frame from the vector table.
        clear_counts();
        run_table("frame");
        chk("frame_vcnt", 72'(vcnt), 72'd4);
        chk("frame_dcnt", 72'(dcnt), 72'd1);
        cycle(1'b0, 8'd0, 8'd0, 8'd0);
        chk("idle_done", 72'(frame_done), 72'd0);

        // Stall of three cycles between p=11 and p=12.
        clear_counts();
        for (int p = 1; p <= 11; p++) send(p);
        chk("stall_p11_valid", 72'(win_valid), 72'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
            chk("stall_valid", 72'(win_valid), 72'd0);
            chk("stall_hold", win_out, mkwin(1, 2, 3, 5, 6, 7, 9, 10, 11));
        end
        send(12);
        chk("stall_p12_win", win_out, mkwin(2, 3, 4, 6, 7, 8, 10, 11, 12));
        chk("stall_p12_valid", 72'(win_valid), 72'd1);
        for (int p = 13; p <= 16; p++) send(p);
        chk("stall_vcnt", 72'(vcnt), 72'd4);
        chk("stall_dcnt", 72'(dcnt), 72'd1);

        // Reset mid-frame after p=9, then a fresh frame.
        for (int p = 1; p <= 9; p++) send(p);
        rst_n = 1'b0;
        cycle(1'b1, 8'd99, 8'd98, 8'd97);
        chk("midrst_win", win_out, 72'd0);
        rst_n = 1'b1;
        clear_counts();
        run_table("after_rst");
        chk("after_rst_vcnt", 72'(vcnt), 72'd4);

        // Two back-to-back frames.
        clear_counts();
        for (int k = 1; k <= 32; k++) send(((k - 1) % 16) + 1);
        chk("b2b_vcnt", 72'(vcnt), 72'd8);
        chk("b2b_dcnt", 72'(dcnt), 72'd2);
        if (done_at.size() == 2) begin
            chk("b2b_done_first", 72'(done_at[0]), 72'd16);
            chk("b2b_done_second", 72'(done_at[1]), 72'd32);
        end else begin
            chk("b2b_done_pulses", 72'(done_at.size()), 72'd2);
        end

        // Randomized traffic with occasional resets, checked by the model.
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            cycle($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning image width in pixels (legal range 3..1024).
REQ-002 SHALL have parameter HEIGHT, default 4, meaning image height in rows (legal range 3..1024).
REQ-003 SHALL have port clk  input  1  meaning the single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port en  input  1  meaning pixel-accept strobe; one raster pixel per cycle with en=1.
REQ-006 SHALL have port row0_in  input  8  meaning current-row pixel, newest.
REQ-007 SHALL have port row1_in  input  8  meaning same column, one row earlier (line_buffer output).
REQ-008 SHALL have port row2_in  input  8  meaning same column, two rows earlier (second line_buffer output).
REQ-009 SHALL have port win_out  output  72  meaning 3x3 window; tap(r,c) at bits [8*(3*r+c)+7 : 8*(3*r+c)]; r=0 oldest row (row2_in), c=0 oldest column.
REQ-010 SHALL have port win_valid  output  1  meaning win_out holds a complete, in-frame window this cycle.
REQ-011 SHALL have port frame_done  output  1  meaning one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-012 Accepted pixel (en=1): all three window rows shift one column toward c=0; row2_in->(0,2), row1_in->(1,2), row0_in->(2,2).
REQ-013 en=0: window registers, counters and state SHALL hold; win_valid and frame_done SHALL be 0 in the following cycle.
REQ-014 Column counter col (0..WIDTH-1) and row counter row (0..HEIGHT-1), width $clog2 of range, advance per accepted pixel.
REQ-015 col at WIDTH-1 wraps to 0 and increments row; row at HEIGHT-1 with col at WIDTH-1 wraps both to 0.
REQ-016 State machine with two states: FILL (rows 0-1 being received) and RUN (rows 2..HEIGHT-1).
REQ-017 FILL->RUN when pixel (row=1, col=WIDTH-1) accepted; RUN->FILL when pixel (row=HEIGHT-1, col=WIDTH-1) accepted.
REQ-018 win_valid SHALL be 1 in the cycle after an accepted pixel with state=RUN and col>=2, else 0; latency exactly 1 cycle.
REQ-019 Windows spanning a row wrap (col 0,1 of a row) SHALL NOT assert win_valid; no padding is generated.
REQ-020 Exactly (WIDTH-2)*(HEIGHT-2) win_valid cycles per frame.
REQ-021 frame_done SHALL be 1 in the cycle after pixel (HEIGHT-1, WIDTH-1) is accepted, coinciding with that pixel's win_valid.
REQ-022 Back-to-back frames: the pixel after frame_done is (row 0, col 0) of the next frame with no idle cycle required.
REQ-023 win_out is registered and holds its last value while win_valid=0; consumers SHALL sample only when win_valid=1.
REQ-024 No arithmetic on pixel data; values pass bit-exact.

Reset
REQ-025 rst_n=0 SHALL immediately clear win_out to 0, win_valid to 0, frame_done to 0, col and row to 0, state to FILL.
REQ-026 Reset asserted mid-frame abandons the frame; the first pixel accepted after release is (row 0, col 0).
REQ-027 rst_n deassertion takes effect on the next rising edge; en sampled in that edge is honoured.

Verification (WIDTH=4, HEIGHT=4, raster pixels p=1..16; bench drives row0_in=p, row1_in=p-4 or 0, row2_in=p-8 or 0)
REQ-028 Reset check: hold rst_n=0 with en toggling -> win_out=0, win_valid=0, frame_done=0 throughout.
REQ-029 Full frame with en=1 continuously -> win_valid high exactly 4 cycles, after pixels 11,12,15,16; window after p=11 = rows {1,2,3},{5,6,7},{9,10,11}, win_out[7:0]=1, win_out[71:64]=11.
REQ-030 Boundary: after p=16 -> window {6,7,8},{10,11,12},{14,15,16} with win_valid=1 and frame_done=1 same cycle; frame_done 0 in all other cycles.
REQ-031 Stall: deassert en for 3 cycles between p=11 and p=12 -> win_valid 0 during stall, window after p=12 = {2,3,4},{6,7,8},{10,11,12}, total valid count still 4.
REQ-032 Reset mid-frame: pulse rst_n low after p=9, then send a fresh full frame -> valid windows identical to REQ-029/REQ-030, no spurious valid.
REQ-033 Two back-to-back frames (32 pixels, en=1) -> 8 win_valid cycles, 2 frame_done pulses after pixels 16 and 32.
